wide_alu_sequencer: RTL and testbench
=====================================

Name: wide_alu_sequencer

Overview:
- Multi-byte operation initiator that drives the 8-bit datapath ALU interface (operands a/b, opControl, carry-in c) and consumes its result and czn flags.
- Executes an NBYTES-wide ADD/AND/OR one byte per cycle, LSB first, chaining carry between bytes.
- Assembles the wide result and the final C/Z/N flags.
- Sits between the multicycle controller (start/done handshake) and the single shared 8-bit ALU instance.

Parameters:
NBYTES, 2, operand width in bytes (W = 8*NBYTES); legal range 1..8

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  2  operation: 00 ADD, 01 AND, 10 OR, 11 invalid
cin  input  1  carry-in for ADD byte 0
opa  input  W  operand A
opb  input  W  operand B
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; res and flags are valid from this cycle
res  output  W  wide result, held until the next accepted start
c_out  output  1  final carry
z_out  output  1  1 when the whole W-bit result is zero
n_out  output  1  res[W-1]
alu_a  output  8  ALU operand a
alu_b  output  8  ALU operand b
alu_op  output  2  ALU opControl
alu_c  output  1  ALU carry-in
alu_result  input  8  ALU result, combinational, same cycle
alu_czn  input  3  ALU flags; only bit 0 (carry) is used

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset: state IDLE; res=0; c_out=0; z_out=0; n_out=0; busy=0; done=0; byte index=0; internal operand/op registers=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - alu_a=0, alu_b=0, alu_op=00, alu_c=0.
  - On start=1 with op in {00,01,10}: latch opa/opb/op; idx<=0; carry reg<=cin if op==00, else 0; res<=0; go to RUN.
  - On start=1 with op==11: res<=0, c_out<=0, z_out<=1, n_out<=0; go directly to DONE.
- RUN (one cycle per byte):
  - alu_a = A[8*idx+:8]; alu_b = B[8*idx+:8]; alu_op = latched op; alu_c = carry reg.
  - At each edge: res[8*idx+:8] <= alu_result; zero-accumulator &= (alu_result==0).
  - Carry reg <= alu_czn[0] for ADD. For AND/OR it stays 0; alu_czn[0] is ignored for AND/OR because the ALU does not update carry there.
  - idx==NBYTES-1 at the edge: c_out<=next carry, z_out<=next zero-accumulator, n_out<=alu_result[7]; go to DONE. Otherwise idx<=idx+1.
- DONE: done=1 for exactly this cycle; unconditional return to IDLE at the next edge.
- Latency: start sampled at edge 0 → NBYTES RUN cycles → done high in the cycle after edge NBYTES → IDLE after edge NBYTES+1. Throughput: one operation per NBYTES+2 cycles.
- start while busy (RUN or DONE) is ignored, not queued.
- Change of opa/opb/op/cin after acceptance has no effect on the operation in flight.
- ADD wraps modulo 2^W; the carry out of the top byte goes to c_out.
- Reset asserted mid-RUN: immediate return to the reset values above; the partial result is discarded; no done pulse.
- res and flags are stable from done until the next accepted start. The clear of res at acceptance is visible in the first RUN cycle.

Decomposition:
- Shared package (alu_defs): ALU op encodings ADD=2'b00, AND=2'b01, OR=2'b10, INVALID=2'b11; czn bit indices C=0, Z=1, N=2; sequencer state encoding.
- No sub-module. The ALU stays an external, separately instantiated block, so the controller may share it.
- Bench connects the existing ALU module to alu_* ports.

Test Plan:
- NBYTES=2, ADD, opa=0x12FF, opb=0x0001, cin=0 → res=0x1300, c=0, z=0, n=0; done exactly 3 cycles after the start edge; alu_c=1 on byte 1.
- ADD 0xFFFF+0x0001, cin=0 → res=0x0000, c=1, z=1, n=0. ADD 0x00FF+0x0000, cin=1 → res=0x0100, c=0.
- AND 0xF0F0 & 0x0FFF → 0x00F0, c=0, z=0, n=0. OR 0x8000 | 0x0001 → 0x8001, n=1. AND 0xFF00 & 0x00FF → 0x0000, z=1; stale ALU carry ignored.
- start pulsed every cycle during RUN/DONE with different operands → only the first is executed; next accepted only from IDLE; result unaffected.
- op=11 → done in the cycle after acceptance, res=0, z=1, c=0, n=0, no RUN cycles.
- Assert rst in the second RUN cycle of ADD 0x1234+0x1111 → all outputs 0, IDLE, no done. A fresh start afterwards yields 0x2345.

Source files
------------

// File: rtl/wide_alu_sequencer_pkg.sv
// Shared ALU encodings and sequencer state type for the multi-byte ALU sequencer.
package alu_defs;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_INV = 2'b11;

  localparam int CZN_C = 0;
  localparam int CZN_Z = 1;
  localparam int CZN_N = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } seq_state_t;

endpackage

// File: rtl/wide_alu_sequencer.sv
// Runs an NBYTES-wide ADD/AND/OR through a shared 8-bit ALU, one byte per cycle, LSB first.
// Latency NBYTES+1 cycles start-to-done; start is ignored (not queued) while busy.
module wide_alu_sequencer
  import alu_defs::*;
#(
  parameter int NBYTES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic                cin,
  input  logic [8*NBYTES-1:0] opa,
  input  logic [8*NBYTES-1:0] opb,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] res,
  output logic                c_out,
  output logic                z_out,
  output logic                n_out,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [1:0]          alu_op,
  output logic                alu_c,
  input  logic [7:0]          alu_result,
  input  logic [2:0]          alu_czn
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  seq_state_t     state, state_nxt;
  logic [W-1:0]   a_q, b_q;
  logic [1:0]     op_q;
  logic [IW-1:0]  idx;
  logic           carry_q;
  logic           zacc_q;
  logic           carry_nxt;
  logic           byte_zero;
  logic           accept;
  logic [IW+2:0]  bit_base;

  // Only the carry flag matters; Z/N are rebuilt across the whole word here.
  logic unused_czn;
  assign unused_czn = ^alu_czn[2:1];

  assign bit_base  = {idx, 3'b000};
  assign byte_zero = (alu_result == 8'd0);
  assign carry_nxt = (op_q == OP_ADD) ? alu_czn[CZN_C] : 1'b0;
  assign accept    = (state == ST_IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    alu_a     = 8'd0;
    alu_b     = 8'd0;
    alu_op    = OP_ADD;
    alu_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (op == OP_INV) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        busy   = 1'b1;
        alu_a  = a_q[bit_base +: 8];
        alu_b  = b_q[bit_base +: 8];
        alu_op = op_q;
        alu_c  = carry_q;
        if (idx == LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      idx     <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      res     <= '0;
      c_out   <= 1'b0;
      z_out   <= 1'b0;
      n_out   <= 1'b0;
    end else if (accept) begin
      res <= '0;
      if (op == OP_INV) begin
        c_out <= 1'b0;
        z_out <= 1'b1;
        n_out <= 1'b0;
      end else begin
        a_q     <= opa;
        b_q     <= opb;
        op_q    <= op;
        idx     <= '0;
        carry_q <= (op == OP_ADD) ? cin : 1'b0;
        zacc_q  <= 1'b1;
      end
    end else if (state == ST_RUN) begin
      res[bit_base +: 8] <= alu_result;
      zacc_q             <= zacc_q & byte_zero;
      carry_q            <= carry_nxt;
      if (idx == LAST) begin
        c_out <= carry_nxt;
        z_out <= zacc_q & byte_zero;
        n_out <= alu_result[7];
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_wide_alu_sequencer.sv
// Directed bench: wide_alu_sequencer (NBYTES=2) driving a behavioural 8-bit ALU model.
module tb_wide_alu_sequencer;
  import alu_defs::*;

  localparam int NB = 2;
  localparam int W  = 8 * NB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic          cin = 1'b0;
  logic [W-1:0]  opa = '0, opb = '0;
  logic          busy, done, c_out, z_out, n_out;
  logic [W-1:0]  res;
  logic [7:0]    alu_a, alu_b, alu_result;
  logic [1:0]    alu_op;
  logic          alu_c;
  logic [2:0]    alu_czn;

  int total = 0;
  int bad   = 0;
  logic c_byte1;

  always #5 clk = ~clk;

  wide_alu_sequencer #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .cin(cin),
    .opa(opa), .opb(opb), .busy(busy), .done(done), .res(res),
    .c_out(c_out), .z_out(z_out), .n_out(n_out),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .alu_result(alu_result), .alu_czn(alu_czn)
  );

  // ALU model; AND/OR leave a stale carry of 1 to prove the sequencer ignores it.
  always_comb begin
    logic [8:0] sum;
    sum        = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_c};
    alu_result = 8'd0;
    alu_czn    = 3'b000;
    case (alu_op)
      OP_ADD: begin
        alu_result     = sum[7:0];
        alu_czn[CZN_C] = sum[8];
      end
      OP_AND: begin
        alu_result     = alu_a & alu_b;
        alu_czn[CZN_C] = 1'b1;
      end
      OP_OR: begin
        alu_result     = alu_a | alu_b;
        alu_czn[CZN_C] = 1'b1;
      end
      default: alu_result = 8'd0;
    endcase
    alu_czn[CZN_Z] = (alu_result == 8'd0);
    alu_czn[CZN_N] = alu_result[7];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Issue one start at edge 0, then count negedges until done (edge k -> count k+1).
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ci, input logic [W-1:0] er,
                        input logic ec, input logic ez, input logic en, input int elat);
    int n;
    @(negedge clk);
    op = o; opa = a; opb = b; cin = ci; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    opa = ~a; opb = ~b; op = OP_OR; cin = ~ci;
    n = 1;
    c_byte1 = 1'b0;
    while (!done && n < 20) begin
      if (n == 2) c_byte1 = alu_c;
      @(negedge clk);
      n++;
    end
    check({tag, ".lat"}, n, elat);
    check({tag, ".res"}, res, er);
    check({tag, ".czn"}, {29'd0, n_out, z_out, c_out}, {29'd0, en, ez, ec});
    @(negedge clk);
    check({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
    check({tag, ".hold"}, res, er);
  endtask

  initial begin
    int n;
    #12;
    check("rst.out", {res, 10'd0, busy, done, c_out, z_out, n_out, 1'b0}, 32'd0);
    check("rst.alu", {alu_a, alu_b, alu_op, alu_c}, 19'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add1", OP_ADD, 16'h12FF, 16'h0001, 1'b0, 16'h1300, 1'b0, 1'b0, 1'b0, NB + 1);
    check("add1.cb1", c_byte1, 1'b1);
    run_op("add2", OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, NB + 1);
    run_op("add3", OP_ADD, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, NB + 1);
    run_op("and1", OP_AND, 16'hF0F0, 16'h0FFF, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0, NB + 1);
    run_op("or1",  OP_OR,  16'h8000, 16'h0001, 1'b0, 16'h8001, 1'b0, 1'b0, 1'b1, NB + 1);
    run_op("and2", OP_AND, 16'hFF00, 16'h00FF, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, NB + 1);
    run_op("inv",  OP_INV, 16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1);

    // start held high with changing operands throughout RUN and DONE
    @(negedge clk);
    op = OP_ADD; opa = 16'h0101; opb = 16'h0101; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    while (!done && n < 20) begin
      opa = opa + 16'h1111; opb = 16'h7777; op = OP_OR; cin = 1'b1;
      @(negedge clk);
      n++;
    end
    check("busy.lat", n, NB + 1);
    check("busy.res", res, 16'h0202);
    @(negedge clk);
    check("busy.idle", busy, 1'b0);
    start = 1'b0;
    @(negedge clk);
    check("busy.noq", busy, 1'b0);
    run_op("after", OP_ADD, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, NB + 1);

    // reset in the second RUN cycle
    @(negedge clk);
    op = OP_ADD; opa = 16'h1234; opb = 16'h1111; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("rrun.busy", busy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rrun.out", {res, 10'd0, busy, done, c_out, z_out, n_out, 1'b0}, 32'd0);
    check("rrun.alu", {alu_a, alu_b, alu_op, alu_c}, 19'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    check("rrun.nodone", n, 0);
    run_op("fresh", OP_ADD, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, NB + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
